// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: byte FIFO, overrun/timeout flags, bus registers, level interrupt
//
// Ports:
//   clk_i     - clock, all state on rising edge
//   rst_i     - synchronous reset, active low
//   rx_data   - received byte, valid while rx_ready = 1
//   rx_ready  - one-cycle strobe marking a new byte
//   cyc_i     - bus cycle
//   stb_i     - bus strobe
//   we_i      - 1 = write, 0 = read
//   adr_i     - register select: 0 DATA, 1 STATUS, 2 CTRL, 3 LEVEL
//   dat_i     - write data
//   dat_o     - read data, 0x00 whenever ack_o = 0
//   ack_o     - one-cycle acknowledge, the cycle after acceptance
//   int_o     - level interrupt
module uart_rx_ctrl #(
    parameter int DEPTH       = 16,
    parameter int IDLE_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [1:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       int_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ovr_q, ovr_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    ctrl_q, ctrl_d;
    logic          ack_q, ack_d;
    logic [7:0]    dat_q, dat_d;

    logic       acc, pop, flush, wr_stat, wr_ctrl;
    logic       push_req, push, ovr_set, tmo_set;
    logic       empty, full;
    logic [7:0] rd_val;
    logic [3:0] thr;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A request is not accepted while its previous ack is still on the bus.
    assign acc     = cyc_i & stb_i & ~ack_q;
    assign pop     = acc & ~we_i & (adr_i == 2'd0) & ~empty;
    assign wr_stat = acc & we_i & (adr_i == 2'd1);
    assign wr_ctrl = acc & we_i & (adr_i == 2'd2);
    assign flush   = acc & we_i & (adr_i == 2'd3) & dat_i[0];

    // Flush discards a simultaneous byte without flagging overrun; a full
    // FIFO still accepts the byte when the head leaves in the same cycle.
    assign push_req = rx_ready & ctrl_q[0] & ~flush;
    assign push     = push_req & (~full | pop);
    assign ovr_set  = push_req & full & ~pop;

    // Reads always reflect state before the accepting edge.
    always_comb begin
        rd_val = 8'h00;
        case (adr_i)
            2'd0:    rd_val = empty ? 8'h00 : mem_q[rptr_q];
            2'd1:    rd_val = {4'b0000, tmo_q, ovr_q, full, ~empty};
            2'd2:    rd_val = ctrl_q;
            default: rd_val = 8'(count_q);
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        idle_d  = idle_q;
        tmo_set = 1'b0;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // Saturation at IDLE_MAX makes the flag set only once per idle period.
        if (push || pop || flush || empty) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d  = idle_q + IW'(1);
            tmo_set = (idle_d == IDLE_MAX);
        end

        // A set in the same cycle as its W1C clear wins.
        ovr_d  = (ovr_q & ~(wr_stat & dat_i[2])) | ovr_set;
        tmo_d  = (tmo_q & ~(wr_stat & dat_i[3])) | tmo_set;
        ctrl_d = wr_ctrl ? dat_i : ctrl_q;
        ack_d  = acc;
        dat_d  = (acc & ~we_i) ? rd_val : 8'h00;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= rx_data;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            idle_q  <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
            ctrl_q  <= 8'h00;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
            ctrl_q  <= ctrl_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    // THR = 0 behaves as 1 so the data interrupt never fires on an empty FIFO.
    assign thr   = (ctrl_q[7:4] == 4'd0) ? 4'd1 : ctrl_q[7:4];
    assign int_o = (ctrl_q[1] & (8'(count_q) >= {4'b0000, thr}))
                 | (ctrl_q[2] & ovr_q)
                 | (ctrl_q[3] & tmo_q);

    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl against a queue-based reference model
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int IDLE  = 8;

    logic       clk;
    logic       rstn;
    logic [7:0] rxd;
    logic       rxr;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dati;
    logic [7:0] dat_o;
    logic       ack_o;
    logic       int_o;

    uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
        .clk_i   (clk),
        .rst_i   (rstn),
        .rx_data (rxd),
        .rx_ready(rxr),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .we_i    (we),
        .adr_i   (adr),
        .dat_i   (dati),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .int_o   (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [7:0] q[$];
    logic       m_ovr, m_tmo, m_ack;
    logic [7:0] m_ctrl, m_dat;
    int         m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic int_exp();
        int t;
        t = (m_ctrl[7:4] == 4'd0) ? 1 : int'(m_ctrl[7:4]);
        return (m_ctrl[1] && q.size() >= t) || (m_ctrl[2] && m_ovr) || (m_ctrl[3] && m_tmo);
    endfunction

    // Applies the current inputs to the model as one clock cycle.
    task automatic model_eval();
        logic       acc, pop, flush, push_ok, ovr_set, tmo_set, was_empty;
        logic [7:0] rv;
        if (!rstn) begin
            q.delete();
            m_ovr = 0; m_tmo = 0; m_ack = 0; m_ctrl = 0; m_dat = 0; m_idle = 0;
        end else begin
            acc = cyc && stb && !m_ack;
            rv = 8'h00;
            if (acc && !we) begin
                case (adr)
                    2'd0: if (q.size() > 0) rv = q[0];
                    2'd1: rv = {4'b0000, m_tmo, m_ovr, q.size() == DEPTH, q.size() != 0};
                    2'd2: rv = m_ctrl;
                    default: rv = 8'(q.size());
                endcase
            end
            was_empty = (q.size() == 0);
            pop     = acc && !we && adr == 2'd0 && !was_empty;
            flush   = acc && we && adr == 2'd3 && dati[0];
            push_ok = 0; ovr_set = 0; tmo_set = 0;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (rxr && m_ctrl[0]) begin
                    if (q.size() < DEPTH) begin
                        q.push_back(rxd);
                        push_ok = 1;
                    end else begin
                        ovr_set = 1;
                    end
                end
            end
            if (push_ok || pop || flush || was_empty) begin
                m_idle = 0;
            end else if (m_idle < IDLE - 1) begin
                m_idle++;
                if (m_idle == IDLE - 1) tmo_set = 1;
            end
            if (acc && we && adr == 2'd1) begin
                if (dati[2]) m_ovr = 0;
                if (dati[3]) m_tmo = 0;
            end
            if (ovr_set) m_ovr = 1;
            if (tmo_set) m_tmo = 1;
            if (acc && we && adr == 2'd2) m_ctrl = dati;
            m_ack = acc;
            m_dat = rv;
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        @(negedge clk);
        chk("ack", 32'(ack_o), 32'(m_ack));
        chk("dat", 32'(dat_o), 32'(m_dat));
        chk("int", 32'(int_o), 32'(int_exp()));
    endtask

    task automatic bus_rx(input logic w, input logic [1:0] a, input logic [7:0] d,
                          input logic rx_en, input logic [7:0] rx_b, output logic [7:0] r);
        cyc = 1; stb = 1; we = w; adr = a; dati = d;
        rxr = rx_en; rxd = rx_b;
        cycle();
        r = dat_o;
        chk("bus_ack", 32'(ack_o), 32'd1);
        cyc = 0; stb = 0; we = 0; rxr = 0;
        cycle();
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] r);
        bus_rx(w, a, d, 1'b0, 8'h00, r);
    endtask

    task automatic push(input logic [7:0] b);
        rxr = 1; rxd = b;
        cycle();
        rxr = 0;
    endtask

    task automatic clean();
        logic [7:0] r;
        bus(1, 2'd3, 8'h01, r);
        bus(1, 2'd1, 8'h0C, r);
    endtask

    task automatic wait_int(input string tag);
        int got;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (int_o && got == 0) got = k;
        end
        chk(tag, 32'(got), 32'd7);
    endtask

    initial begin
        logic [7:0] r;
        logic [5:0] ackv;
        int mode;

        rstn = 0; rxr = 0; rxd = 0; cyc = 0; stb = 0; we = 0; adr = 0; dati = 0;
        cycle(); cycle();
        rstn = 1;
        cycle();
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_dat", 32'(dat_o), 0);
        chk("rst_int", 32'(int_o), 0);
        bus(0, 2'd3, 0, r); chk("rst_level", 32'(r), 0);
        bus(0, 2'd1, 0, r); chk("rst_status", 32'(r), 0);

        // Basic receive and read-back
        bus(1, 2'd2, 8'h13, r);
        chk("basic_int0", 32'(int_o), 0);
        push(8'h41);
        chk("basic_int1", 32'(int_o), 1);
        push(8'h42);
        bus(0, 2'd3, 0, r); chk("basic_level2", 32'(r), 2);
        bus(0, 2'd0, 0, r); chk("basic_d0", 32'(r), 8'h41);
        bus(0, 2'd0, 0, r); chk("basic_d1", 32'(r), 8'h42);
        bus(0, 2'd3, 0, r); chk("basic_level0", 32'(r), 0);
        chk("basic_int_off", 32'(int_o), 0);
        bus(0, 2'd0, 0, r); chk("basic_empty_rd", 32'(r), 0);

        // Overrun and wrap-around
        bus(1, 2'd2, 8'h01, r);
        clean();
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        bus(0, 2'd1, 0, r); chk("ovr_status", 32'(r), 8'h07);
        for (int i = 0; i < 16; i++) begin
            bus(0, 2'd0, 0, r); chk("ovr_data", 32'(r), 32'(i));
        end
        bus(1, 2'd1, 8'h04, r);
        bus(0, 2'd1, 0, r); chk("ovr_cleared", 32'(r), 8'h00);
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h80 + i));
            bus(0, 2'd0, 0, r); chk("wrap_data", 32'(r), 32'(8'h80 + i));
        end

        // Simultaneous events
        clean();
        for (int i = 0; i < 16; i++) push(8'(i));
        bus_rx(0, 2'd0, 0, 1, 8'hEE, r); chk("sim_full_pop", 32'(r), 8'h00);
        bus(0, 2'd3, 0, r); chk("sim_full_level", 32'(r), 16);
        bus(0, 2'd1, 0, r); chk("sim_full_status", 32'(r), 8'h03);
        for (int i = 1; i < 16; i++) begin
            bus(0, 2'd0, 0, r); chk("sim_drain", 32'(r), 32'(i));
        end
        bus(0, 2'd0, 0, r); chk("sim_drain_last", 32'(r), 8'hEE);
        clean();
        push(8'h10); push(8'h11); push(8'h12);
        bus_rx(0, 2'd0, 0, 1, 8'h13, r); chk("sim3_pop", 32'(r), 8'h10);
        bus(0, 2'd3, 0, r); chk("sim3_level", 32'(r), 3);
        clean();
        for (int i = 0; i < 16; i++) push(8'(i));
        bus_rx(1, 2'd3, 8'h01, 1, 8'h77, r);
        bus(0, 2'd3, 0, r); chk("flush_push_level", 32'(r), 0);
        bus(0, 2'd1, 0, r); chk("flush_push_status", 32'(r), 8'h00);

        // Timeout
        bus(1, 2'd2, 8'h09, r);
        clean();
        chk("tmo_int0", 32'(int_o), 0);
        push(8'hC3);
        wait_int("tmo_latency");
        bus(1, 2'd1, 8'h08, r);
        for (int k = 0; k < 10; k++) cycle();
        chk("tmo_stays_clear", 32'(int_o), 0);
        bus(0, 2'd1, 0, r); chk("tmo_status", 32'(r), 8'h01);
        push(8'hC4);
        wait_int("tmo_latency2");

        // Bus handshake with held request
        bus(1, 2'd2, 8'h01, r);
        clean();
        push(8'h01); push(8'h02); push(8'h03);
        cyc = 1; stb = 1; we = 0; adr = 2'd0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            ackv[k] = ack_o;
        end
        cyc = 0; stb = 0;
        cycle();
        chk("hs_ack_pattern", 32'(ackv), 32'(6'b010101));
        bus(0, 2'd3, 0, r); chk("hs_level", 32'(r), 0);

        // Reset during accepted read
        bus(1, 2'd2, 8'h03, r);
        push(8'h5A);
        chk("prerst_int", 32'(int_o), 1);
        cyc = 1; stb = 1; we = 0; adr = 2'd0; rstn = 0;
        cycle();
        chk("midrst_ack", 32'(ack_o), 0);
        chk("midrst_dat", 32'(dat_o), 0);
        chk("midrst_int", 32'(int_o), 0);
        rstn = 1; cyc = 0; stb = 0;
        cycle();
        chk("postrst_ack", 32'(ack_o), 0);
        bus(0, 2'd2, 0, r); chk("postrst_ctrl", 32'(r), 0);

        // Disabled controller
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        bus(0, 2'd3, 0, r); chk("dis_level", 32'(r), 0);
        bus(0, 2'd1, 0, r); chk("dis_status", 32'(r), 0);
        bus(1, 2'd2, 8'h01, r);
        push(8'h55); push(8'h66);
        bus(0, 2'd3, 0, r); chk("reen_level", 32'(r), 2);
        bus(0, 2'd0, 0, r); chk("reen_d0", 32'(r), 8'h55);
        bus(0, 2'd0, 0, r); chk("reen_d1", 32'(r), 8'h66);

        // Randomized traffic against the model
        mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) mode = $urandom_range(0, 2);
            rxr  = ($urandom_range(0, 99) < (mode == 0 ? 3 : (mode == 1 ? 30 : 75)));
            rxd  = 8'($urandom);
            cyc  = ($urandom_range(0, 99) < 40);
            stb  = cyc ? ($urandom_range(0, 9) < 8) : 1'($urandom_range(0, 1));
            we   = ($urandom_range(0, 3) == 0);
            adr  = 2'($urandom);
            dati = 8'($urandom);
            if (we && adr == 2'd2) dati[0] = ($urandom_range(0, 9) != 0);
            if (we && adr == 2'd3) dati[0] = ($urandom_range(0, 7) == 0);
            rstn = ($urandom_range(0, 999) != 0);
            cycle();
        end
        rstn = 1; rxr = 0; cyc = 0; stb = 0; we = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
